gcbp_bram_read_seq: RTL

Read-side sequencer for the GCBP bit-plane BRAM array. On each start pulse it latches which BRAM locations hold the current and previous sub-images. It then walks every vertical search offset, issuing interleaved current-line and previous-line read addresses on the single BRAM read port. Each returned word pair is handed to the correlator with tags for shift index and line number. It sits between the frame-location rotation logic (which supplies the location indices) and the correlator.

---
 rtl/gcbp_bram_read_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/gcbp_bram_read_seq.sv
// Read sequencer for the GCBP bit-plane BRAM: walks every vertical shift and line,
// interleaving current/previous frame reads, and hands tagged word pairs to the correlator.
//   state     | meaning
//   S_IDLE    | waiting for i_start
//   S_RD_CURR | issuing current-frame read of line y
//   S_RD_PREV | issuing previous-frame read of line y+dy, then advancing y/s
//   S_DRAIN   | reads finished, waiting for the final pair to leave the pipeline
module gcbp_bram_read_seq #(
  parameter int C_LINES                   = 64,
  parameter int C_MAX_SHIFT               = 8,
  parameter int C_SUBIMAGE_OFFSET_IN_BRAM = 128,
  parameter int C_DATA_WIDTH              = 128,
  parameter int C_ADDR_WIDTH              = 9,
  localparam int SW = $clog2(2*C_MAX_SHIFT+1),
  localparam int LW = $clog2(C_LINES)
) (
  input  logic                    i_clk,
  input  logic                    i_resetn,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [1:0]              i_curr_frame_loc,
  input  logic [1:0]              i_prev_frame_loc,
  output logic                    o_bram_rd_en,
  output logic [C_ADDR_WIDTH-1:0] o_bram_rd_addr,
  input  logic [C_DATA_WIDTH-1:0] i_bram_rdata,
  output logic                    o_pair_valid,
  output logic [C_DATA_WIDTH-1:0] o_curr_word,
  output logic [C_DATA_WIDTH-1:0] o_prev_word,
  output logic [SW-1:0]           o_shift_idx,
  output logic [LW-1:0]           o_line,
  output logic                    o_shift_done,
  output logic                    o_frame_done,
  output logic                    o_busy
);

  localparam logic [LW-1:0] Y_FIRST = LW'(C_MAX_SHIFT);
  localparam logic [LW-1:0] Y_LAST  = LW'(C_LINES - 1 - C_MAX_SHIFT);
  localparam logic [SW-1:0] S_LAST  = SW'(2*C_MAX_SHIFT);

  typedef enum logic [1:0] {S_IDLE, S_RD_CURR, S_RD_PREV, S_DRAIN} state_t;

  state_t                  r_state, w_next;
  logic [1:0]              r_curr_loc, r_prev_loc;
  logic [SW-1:0]           r_s;
  logic [LW-1:0]           r_y;
  logic                    r_pv_curr, r_pv_prev;
  logic [C_DATA_WIDTH-1:0] r_curr_hold;
  logic [SW-1:0]           r_tag_s;
  logic [LW-1:0]           r_tag_y;
  logic                    r_tag_sd, r_tag_fd;

  logic                    w_accept, w_abort, w_last_y, w_last_s;
  logic                    w_rd_en;
  logic [C_ADDR_WIDTH-1:0] w_rd_addr, w_curr_addr, w_prev_addr;

  assign w_accept = (r_state == S_IDLE) && i_start && !i_abort;
  assign w_abort  = (r_state != S_IDLE) && i_abort;
  assign w_last_y = (r_y == Y_LAST);
  assign w_last_s = (r_s == S_LAST);

  // Modular arithmetic: y+s-C_MAX_SHIFT never goes negative for in-range counters.
  assign w_curr_addr = C_ADDR_WIDTH'(r_curr_loc) * C_ADDR_WIDTH'(C_SUBIMAGE_OFFSET_IN_BRAM)
                     + C_ADDR_WIDTH'(r_y);
  assign w_prev_addr = C_ADDR_WIDTH'(r_prev_loc) * C_ADDR_WIDTH'(C_SUBIMAGE_OFFSET_IN_BRAM)
                     + C_ADDR_WIDTH'(r_y) + C_ADDR_WIDTH'(r_s) - C_ADDR_WIDTH'(C_MAX_SHIFT);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_rd_en   = 1'b0;
    w_rd_addr = '0;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_RD_CURR;
      S_RD_CURR: begin
        w_rd_en   = 1'b1;
        w_rd_addr = w_curr_addr;
        w_next    = S_RD_PREV;
      end
      S_RD_PREV: begin
        w_rd_en   = 1'b1;
        w_rd_addr = w_prev_addr;
        w_next    = (w_last_s && w_last_y) ? S_DRAIN : S_RD_CURR;
      end
      S_DRAIN:   if (o_frame_done) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  assign o_bram_rd_en   = w_rd_en;
  assign o_bram_rd_addr = w_rd_addr;
  assign o_busy         = (r_state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_curr_loc <= '0;
      r_prev_loc <= '0;
      r_s        <= '0;
      r_y        <= '0;
    end else if (w_accept) begin
      r_curr_loc <= i_curr_frame_loc;
      r_prev_loc <= i_prev_frame_loc;
      r_s        <= '0;
      r_y        <= Y_FIRST;
    end else if (r_state == S_RD_PREV && !w_abort) begin
      if (w_last_y) begin
        r_y <= Y_FIRST;
        if (!w_last_s) r_s <= r_s + 1'b1;
      end else begin
        r_y <= r_y + 1'b1;
      end
    end
  end

  // Tags follow the prev read; the pair leaves one cycle after its prev data returns.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_pv_curr    <= 1'b0;
      r_pv_prev    <= 1'b0;
      r_curr_hold  <= '0;
      r_tag_s      <= '0;
      r_tag_y      <= '0;
      r_tag_sd     <= 1'b0;
      r_tag_fd     <= 1'b0;
      o_pair_valid <= 1'b0;
      o_shift_done <= 1'b0;
      o_frame_done <= 1'b0;
      o_curr_word  <= '0;
      o_prev_word  <= '0;
      o_shift_idx  <= '0;
      o_line       <= '0;
    end else if (w_abort) begin
      r_pv_curr    <= 1'b0;
      r_pv_prev    <= 1'b0;
      o_pair_valid <= 1'b0;
      o_shift_done <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      r_pv_curr    <= (r_state == S_RD_CURR);
      r_pv_prev    <= (r_state == S_RD_PREV);
      if (r_state == S_RD_PREV) begin
        r_tag_s  <= r_s;
        r_tag_y  <= r_y;
        r_tag_sd <= w_last_y;
        r_tag_fd <= w_last_y && w_last_s;
      end
      if (r_pv_curr) r_curr_hold <= i_bram_rdata;
      o_pair_valid <= r_pv_prev;
      o_shift_done <= r_pv_prev && r_tag_sd;
      o_frame_done <= r_pv_prev && r_tag_fd;
      if (r_pv_prev) begin
        o_prev_word <= i_bram_rdata;
        o_curr_word <= r_curr_hold;
        o_shift_idx <= r_tag_s;
        o_line      <= r_tag_y;
      end
    end
  end

endmodule
